cga_vram_sched: RTL and testbench
=================================

Name: cga_vram_sched

Overview:
- Time-slot scheduler that shares the single-port CGA video RAM between CRTC display fetches and CPU accesses.
- Each character slot, fetches the character byte and attribute byte for the CRTC address, then hands the remaining cycles to a single pending CPU read or write.
- Delivers char_byte/att_byte to the character generator and attribute stage, one slot later.
- Also generates the frame-based cursor blink signal consumed by the attribute stage.

Parameters:
ADDR_WIDTH, 14, byte address width of video RAM (16 KB)
BLINK_FRAMES, 16, vsync rising edges per blink toggle; legal range 2..255

Ports:
clk  in  1  pixel-domain clock
reset_n  in  1  asynchronous active-low reset
char_strobe  in  1  one-cycle pulse at start of each character slot; at least 4 cycles apart
fetch_en  in  1  display fetch enable (display active), sampled with char_strobe
disp_addr  in  ADDR_WIDTH-1  CRTC character (word) address, sampled with char_strobe
vsync  in  1  vertical sync, level
cpu_req  in  1  one-cycle request pulse; ignored while cpu_busy=1
cpu_we  in  1  1=write, 0=read; sampled with cpu_req
cpu_addr  in  ADDR_WIDTH  CPU byte address; sampled with cpu_req
cpu_din  in  8  CPU write data; sampled with cpu_req
cpu_busy  out  1  request pending or in flight
cpu_ack  out  1  one-cycle completion pulse
cpu_dout  out  8  read data, valid while cpu_ack=1
ram_addr  out  ADDR_WIDTH  RAM address
ram_we  out  1  RAM write strobe
ram_din  out  8  RAM write data
ram_q  in  8  RAM read data; registered, 1-cycle latency
char_byte  out  8  character code for the current slot
att_byte  out  8  attribute byte for the current slot
blink  out  1  cursor blink phase

Behaviour:
- Reset (async, reset_n=0):
  - All outputs are 0.
  - Internal state is IDLE; pending flag is cleared, holding registers are 0, frame counter is 0.
  - Reset mid-access abandons the access silently; no cpu_ack follows reset release.
- Slot sequence, relative to the strobe cycle S:
  - S: if fetch_en=1, issue ram_addr={disp_addr,0}, ram_we=0 (state FETCH_C).
  - S+1: issue {disp_addr,1}, ram_we=0 (state FETCH_A).
  - S+2: capture ram_q into char_next.
  - S+3: capture ram_q into att_next.
  - Next strobe: char_byte<=char_next and att_byte<=att_next. Display data latency is exactly one slot.
- fetch_en=0 at a strobe: no display issue occurs; char_next and att_next are loaded 0x00, so a blank character is delivered one slot later.
- CPU request path:
  - cpu_req with cpu_busy=0 captures we/addr/din into holding registers; cpu_busy=1 from the next cycle.
  - cpu_req while cpu_busy=1 is dropped.
- CPU issue:
  - Occurs in any cycle where pending=1, the cycle is not a display issue cycle (strobe with fetch_en, or FETCH_A), and no other CPU access is in flight.
  - The issue cycle drives ram_addr/ram_we/ram_din from the holding registers.
- CPU completion:
  - Issue+1: cpu_ack=1 and cpu_busy=0.
  - For reads, cpu_dout=ram_q in that cycle; for writes, cpu_dout is 0.
  - Earliest next capture is the ack cycle itself, with issue the cycle after.
- Priority and collisions:
  - Display issue always wins. A cpu_req coinciding with char_strobe is captured but issues no earlier than S+2.
  - A CPU read issued at S-1 returns at S. Its data does not collide with the char data at S+2.
- Idle cycles: ram_we=0; ram_addr holds its last value.
- States: IDLE, FETCH_C, FETCH_A, CPU_ISSUE. Capture of char_next/att_next runs from a separate 2-bit delay pipe, concurrent with state.
- char_strobe arriving while in FETCH_A is a protocol violation. The current slot's FETCH_A completes; the new strobe is ignored.
- Blink:
  - vsync is registered twice for edge detection.
  - On each rising edge the frame counter increments. When it reaches BLINK_FRAMES-1, it wraps to 0 and blink toggles.

Decomposition:
- Shared package cga_pkg holds the state enum, the default ADDR_WIDTH, and BLINK_FRAMES.
- One sub-module, cga_blink_gen (vsync edge detect and frame counter), is natural; the arbitration and fetch pipe remain in the top.

Test Plan:
- Display fetch: RAM[0x0200]=0x41, RAM[0x0201]=0x1E; strobe with disp_addr=0x100, fetch_en=1 → ram_addr 0x200 at S, 0x201 at S+1; at next strobe+0 char_byte=0x41, att_byte=0x1E.
- Collision: cpu_req read 0x0300 in strobe cycle → FETCH_C, FETCH_A first; CPU issue at S+2; cpu_ack at S+3 with cpu_dout=RAM[0x300]; char/att values unaffected.
- Write then read: write 0x5A to 0x0010 with no strobes → ram_we=1 one cycle, ack next; a subsequent read of 0x0010 returns 0x5A.
- Busy drop: cpu_req write 0x11 to 0x20, then second cpu_req (0x22 to 0x21) while busy → only 0x20 written; RAM[0x21] unchanged; exactly one cpu_ack.
- fetch_en=0: strobe → no RAM read issued by display; next slot char_byte=att_byte=0x00; a pending CPU request issues in the strobe cycle.
- Blink and reset: 16 vsync pulses → blink 0→1; 32 → back to 0. Assert reset_n=0 between CPU issue and ack → cpu_ack never pulses, all outputs 0, blink 0.

Source files
------------

// File: rtl/cga_pkg.sv
// Shared state encoding and default sizing for the CGA video RAM scheduler.
package cga_pkg;

  localparam int unsigned CGA_ADDR_WIDTH   = 14;
  localparam int unsigned CGA_BLINK_FRAMES = 16;
  localparam int unsigned CGA_DATA_WIDTH   = 8;
  localparam int unsigned CGA_BLINK_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FETCH_C   = 2'd1,
    ST_FETCH_A   = 2'd2,
    ST_CPU_ISSUE = 2'd3
  } sched_state_e;

endpackage

// File: rtl/cga_blink_gen.sv
// Frame-based cursor blink: counts vsync rising edges and toggles blink
// every BLINK_FRAMES frames.
module cga_blink_gen
  import cga_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = CGA_BLINK_FRAMES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic vsync,
  output logic blink
);

  logic [1:0]                 vs_q;
  logic [CGA_BLINK_CNT_W-1:0] frame_q;
  logic                       vs_rise;

  assign vs_rise = vs_q[0] & ~vs_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q    <= '0;
      frame_q <= '0;
      blink   <= 1'b0;
    end else begin
      vs_q <= {vs_q[0], vsync};
      if (vs_rise) begin
        if (frame_q == CGA_BLINK_CNT_W'(BLINK_FRAMES - 1)) begin
          frame_q <= '0;
          blink   <= ~blink;
        end else begin
          frame_q <= frame_q + CGA_BLINK_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cga_vram_sched.sv
// Single-port video RAM arbiter: two display fetches per character slot,
// remaining cycles serve one pending CPU access; also hosts the blink generator.
module cga_vram_sched
  import cga_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = CGA_ADDR_WIDTH,
  parameter int unsigned BLINK_FRAMES = CGA_BLINK_FRAMES
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  char_strobe,
  input  logic                  fetch_en,
  input  logic [ADDR_WIDTH-2:0] disp_addr,
  input  logic                  vsync,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [7:0]            cpu_din,
  output logic                  cpu_busy,
  output logic                  cpu_ack,
  output logic [7:0]            cpu_dout,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [7:0]            ram_din,
  input  logic [7:0]            ram_q,
  output logic [7:0]            char_byte,
  output logic [7:0]            att_byte,
  output logic                  blink
);

  sched_state_e          st_q, st_d;
  logic [ADDR_WIDTH-2:0] disp_q;
  logic                  hold_we_q;
  logic [ADDR_WIDTH-1:0] hold_addr_q;
  logic [7:0]            hold_din_q;
  logic                  ack_rd_q;
  logic [1:0]            cap_q;
  logic [7:0]            char_next_q, att_next_q;

  logic                  in_fetch, strobe_ok, start_fetch, cpu_go;
  logic [ADDR_WIDTH-1:0] ram_addr_d;
  logic                  ram_we_d;
  logic [7:0]            ram_din_d;

  // Next-state and RAM port selection; display fetches always win the port.
  always_comb begin
    in_fetch    = (st_q == ST_FETCH_C) || (st_q == ST_FETCH_A);
    strobe_ok   = char_strobe && !in_fetch;
    start_fetch = strobe_ok && fetch_en;
    cpu_go      = cpu_busy && (st_q != ST_CPU_ISSUE);
    st_d        = ST_IDLE;
    ram_addr_d  = ram_addr;
    ram_we_d    = 1'b0;
    ram_din_d   = ram_din;

    if (st_q == ST_FETCH_C) begin
      st_d = ST_FETCH_A;
    end else if (start_fetch) begin
      st_d = ST_FETCH_C;
    end else if (cpu_go) begin
      st_d = ST_CPU_ISSUE;
    end

    case (st_d)
      ST_FETCH_C:   ram_addr_d = {disp_addr, 1'b0};
      ST_FETCH_A:   ram_addr_d = {disp_q, 1'b1};
      ST_CPU_ISSUE: begin
        ram_addr_d = hold_addr_q;
        ram_we_d   = hold_we_q;
        ram_din_d  = hold_din_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q        <= ST_IDLE;
      disp_q      <= '0;
      hold_we_q   <= 1'b0;
      hold_addr_q <= '0;
      hold_din_q  <= '0;
      ack_rd_q    <= 1'b0;
      cap_q       <= '0;
      char_next_q <= '0;
      att_next_q  <= '0;
      cpu_busy    <= 1'b0;
      cpu_ack     <= 1'b0;
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      ram_din     <= '0;
      char_byte   <= '0;
      att_byte    <= '0;
    end else begin
      st_q     <= st_d;
      ram_addr <= ram_addr_d;
      ram_we   <= ram_we_d;
      ram_din  <= ram_din_d;
      cpu_ack  <= (st_q == ST_CPU_ISSUE);
      ack_rd_q <= (st_q == ST_CPU_ISSUE) && !hold_we_q;
      // Read data for FETCH_C/FETCH_A appears on ram_q one and two cycles later.
      cap_q    <= {cap_q[0], (st_q == ST_FETCH_C)};

      if (cpu_req && !cpu_busy) begin
        cpu_busy    <= 1'b1;
        hold_we_q   <= cpu_we;
        hold_addr_q <= cpu_addr;
        hold_din_q  <= cpu_din;
      end else if (st_q == ST_CPU_ISSUE) begin
        cpu_busy <= 1'b0;
      end

      if (start_fetch) begin
        disp_q <= disp_addr;
      end

      if (strobe_ok) begin
        char_byte <= char_next_q;
        att_byte  <= att_next_q;
        if (!fetch_en) begin
          char_next_q <= '0;
          att_next_q  <= '0;
        end
      end
      if (cap_q[0]) begin
        char_next_q <= ram_q;
      end
      if (cap_q[1]) begin
        att_next_q <= ram_q;
      end
    end
  end

  // Read data is passed straight from the RAM output register during the ack cycle.
  assign cpu_dout = ack_rd_q ? ram_q : 8'h00;

  cga_blink_gen #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk     (clk),
    .reset_n (reset_n),
    .vsync   (vsync),
    .blink   (blink)
  );

endmodule

// File: tb/tb_cga_vram_sched.sv
// Self-checking bench for cga_vram_sched: directed slot/CPU/blink scenarios
// plus randomized traffic against a byte-array model of video RAM.
module tb_cga_vram_sched;

  localparam int unsigned AW    = 14;
  localparam int unsigned RAM_N = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          char_strobe = 1'b0;
  logic          fetch_en = 1'b0;
  logic [AW-2:0] disp_addr = '0;
  logic          vsync = 1'b0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_din = '0;
  logic          cpu_busy, cpu_ack, ram_we, blink;
  logic [7:0]    cpu_dout, ram_din, char_byte, att_byte;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_q;

  logic [7:0]    ram [RAM_N];
  logic [7:0]    mdl [RAM_N];
  logic          ram_init = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] seed_byte(input int unsigned a);
    if (a == 32'h200) return 8'h41;
    if (a == 32'h201) return 8'h1E;
    return 8'((a * 32'd157 + (a >> 7)) ^ 32'hA5);
  endfunction

  // Video RAM with registered read data; contents seeded on the first clock.
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < RAM_N; i++) ram[i] <= seed_byte(i);
      ram_init <= 1'b1;
    end else if (ram_we) begin
      ram[ram_addr] <= ram_din;
    end
    ram_q <= ram[ram_addr];
  end

  cga_vram_sched #(.ADDR_WIDTH(AW), .BLINK_FRAMES(16)) dut (
    .clk(clk), .reset_n(reset_n), .char_strobe(char_strobe), .fetch_en(fetch_en),
    .disp_addr(disp_addr), .vsync(vsync), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_busy(cpu_busy), .cpu_ack(cpu_ack),
    .cpu_dout(cpu_dout), .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
    .ram_q(ram_q), .char_byte(char_byte), .att_byte(att_byte), .blink(blink)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one CPU access (busy must be low) and waits, bounded, for its ack.
  task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic got);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
    step();
    cpu_req = 1'b0;
    got = 1'b0; rd = 8'h00;
    for (int i = 0; i < 16 && !got; i++) begin
      step();
      if (cpu_ack) begin got = 1'b1; rd = cpu_dout; end
    end
  endtask

  task automatic vs_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b1; repeat (2) step();
      vsync = 1'b0; repeat (2) step();
    end
  endtask

  initial begin
    logic [7:0]    rd, exp_c, exp_a;
    logic          got, fe;
    logic [AW-2:0] dd;
    logic [AW-1:0] a, ca;
    logic [7:0]    d;
    int            acks, off, kind;

    for (int i = 0; i < RAM_N; i++) mdl[i] = seed_byte(i);
    repeat (3) step();

    // Reset values
    chk("rst_busy", cpu_busy, 0);   chk("rst_ack", cpu_ack, 0);
    chk("rst_dout", cpu_dout, 0);   chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_we", ram_we, 0);   chk("rst_ram_din", ram_din, 0);
    chk("rst_char", char_byte, 0);  chk("rst_att", att_byte, 0);
    chk("rst_blink", blink, 0);
    reset_n = 1'b1;
    step();

    // Display fetch of 0x100 -> char 0x200, attribute 0x201
    char_strobe = 1'b1; fetch_en = 1'b1; disp_addr = 13'h100;
    step(); char_strobe = 1'b0;
    chk("fc_addr", ram_addr, 14'h200); chk("fc_we", ram_we, 0);
    step();
    chk("fa_addr", ram_addr, 14'h201); chk("fa_we", ram_we, 0);
    repeat (2) step();
    char_strobe = 1'b1; fetch_en = 1'b0;
    step(); char_strobe = 1'b0;
    chk("disp_char", char_byte, 8'h41); chk("disp_att", att_byte, 8'h1E);

    // fetch_en=0 slot: blank delivered, pending CPU read takes the strobe cycle
    step();
    a = 14'h0123;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    step(); cpu_req = 1'b0;
    chk("fe0_busy", cpu_busy, 1);
    char_strobe = 1'b1; fetch_en = 1'b0;
    step(); char_strobe = 1'b0;
    chk("fe0_char", char_byte, 0); chk("fe0_att", att_byte, 0);
    chk("fe0_cpu_addr", ram_addr, a); chk("fe0_cpu_we", ram_we, 0);
    step();
    chk("fe0_ack", cpu_ack, 1); chk("fe0_dout", cpu_dout, mdl[a]);
    chk("fe0_busy_clr", cpu_busy, 0);
    step();

    // Collision: CPU read captured with the strobe waits for both display issues
    dd = 13'h1000 | 13'($urandom_range(0, 13'hFFF));
    ca = {dd, 1'b0};
    char_strobe = 1'b1; fetch_en = 1'b1; disp_addr = dd;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0300;
    step(); char_strobe = 1'b0; cpu_req = 1'b0;
    chk("col_fc_addr", ram_addr, ca); chk("col_busy", cpu_busy, 1);
    step();
    chk("col_fa_addr", ram_addr, ca | 14'h1);
    step();
    chk("col_cpu_addr", ram_addr, 14'h0300); chk("col_ack_early", cpu_ack, 0);
    step();
    chk("col_ack", cpu_ack, 1); chk("col_dout", cpu_dout, mdl[14'h0300]);
    char_strobe = 1'b1; fetch_en = 1'b0;
    step(); char_strobe = 1'b0;
    chk("col_char", char_byte, mdl[ca]); chk("col_att", att_byte, mdl[ca | 14'h1]);

    // Write then read back, no strobes
    repeat (4) step();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0010; cpu_din = 8'h5A;
    step(); cpu_req = 1'b0;
    step();
    chk("wr_we", ram_we, 1); chk("wr_addr", ram_addr, 14'h0010); chk("wr_din", ram_din, 8'h5A);
    step();
    chk("wr_ack", cpu_ack, 1); chk("wr_we_off", ram_we, 0);
    chk("wr_dout", cpu_dout, 0); chk("wr_busy", cpu_busy, 0);
    mdl[14'h0010] = 8'h5A;
    cpu_op(1'b0, 14'h0010, 8'h00, rd, got);
    chk("rd_ack", got, 1); chk("rd_data", rd, 8'h5A);
    step();

    // Request while busy is dropped
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0020; cpu_din = 8'h11;
    step();
    chk("drop_busy", cpu_busy, 1);
    cpu_addr = 14'h0021; cpu_din = 8'h22;
    step(); cpu_req = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      if (cpu_ack) acks++;
      step();
    end
    chk("drop_ack_count", acks, 1);
    mdl[14'h0020] = 8'h11;
    cpu_op(1'b0, 14'h0020, 8'h00, rd, got);
    chk("drop_rd20", rd, mdl[14'h0020]);
    step();
    cpu_op(1'b0, 14'h0021, 8'h00, rd, got);
    chk("drop_rd21", rd, mdl[14'h0021]);
    step();

    // Randomized CPU traffic and display slots against the RAM model
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 2);
      a = AW'($urandom);
      d = 8'($urandom);
      if (kind == 0) begin
        cpu_op(1'b1, a, d, rd, got);
        chk("rnd_wr_ack", got, 1);
        mdl[a] = d;
      end else if (kind == 1) begin
        cpu_op(1'b0, a, 8'h00, rd, got);
        chk("rnd_rd_ack", got, 1); chk("rnd_rd_data", rd, mdl[a]);
      end else begin
        dd = AW'($urandom) >> 1;
        ca = {dd, 1'b0};
        fe = 1'($urandom);
        off = $urandom_range(0, 3);
        exp_c = fe ? mdl[ca] : 8'h00;
        exp_a = fe ? mdl[ca | 14'h1] : 8'h00;
        acks = 0; rd = 8'h00;
        for (int c = 0; c < 8; c++) begin
          char_strobe = (c == 0); fetch_en = fe; disp_addr = dd;
          cpu_req = (c == off); cpu_we = 1'b0; cpu_addr = a;
          step();
          if (cpu_ack) begin acks++; rd = cpu_dout; end
        end
        cpu_req = 1'b0;
        chk("rnd_slot_acks", acks, 1); chk("rnd_slot_rd", rd, mdl[a]);
        char_strobe = 1'b1; fetch_en = 1'b0;
        step(); char_strobe = 1'b0;
        chk("rnd_char", char_byte, exp_c); chk("rnd_att", att_byte, exp_a);
      end
      step();
    end

    // Blink: toggles on the 16th and 32nd vsync rising edge
    vs_pulses(15); chk("blink_15", blink, 0);
    vs_pulses(1);  chk("blink_16", blink, 1);
    vs_pulses(15); chk("blink_31", blink, 1);
    vs_pulses(1);  chk("blink_32", blink, 0);
    vs_pulses(8);

    // Reset between CPU issue and ack
    step();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0777; cpu_din = 8'hC3;
    step(); cpu_req = 1'b0;
    step();
    chk("mid_issue_addr", ram_addr, 14'h0777);
    reset_n = 1'b0;
    #1;
    chk("mid_busy", cpu_busy, 0);  chk("mid_ack", cpu_ack, 0);
    chk("mid_dout", cpu_dout, 0);  chk("mid_ram_addr", ram_addr, 0);
    chk("mid_ram_we", ram_we, 0);  chk("mid_ram_din", ram_din, 0);
    chk("mid_char", char_byte, 0); chk("mid_att", att_byte, 0);
    chk("mid_blink", blink, 0);
    step();
    reset_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (cpu_ack) acks++;
    end
    chk("mid_no_ack", acks, 0);
    vs_pulses(15); chk("post_rst_blink_15", blink, 0);
    vs_pulses(1);  chk("post_rst_blink_16", blink, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
